sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 780, meaning clock cycles between refresh credits (7.8 us at 100 MHz).
REQ-002 SHALL have parameter REFRESH_URGENT, default 4, meaning pending-credit count at which refresh preempts all requesters.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, meaning consecutive video grants allowed while a CPU request waits.
REQ-004 SHALL have the following ports, one per line as name  direction  width  meaning:
  clock  in  1  100 MHz system clock; the only clock.
  reset_n  in  1  asynchronous active-low reset.
  init_done  in  1  SDRAM init sequence finished; arbitration is disabled while low.
  vid_req  in  1  video line-fetch request; held high until vid_ack.
  vid_addr  in  22  video burst start word address.
  vid_len  in  8  video burst length in words, 1..255; 0 is treated as 1.
  vid_ack  out  1  one-cycle pulse on video completion.
  cpu_req  in  1  CPU single-word request; held high until cpu_ack.
  cpu_we  in  1  1 = write, 0 = read.
  cpu_addr  in  22  CPU word address.
  cpu_wdata  in  16  CPU write data.
  cpu_rdata  out  16  CPU read data; valid from cpu_ack onward.
  cpu_ack  out  1  one-cycle pulse on CPU completion.
  eng_start  out  1  one-cycle pulse starting a command-engine operation.
  eng_op  out  2  00 burst read, 01 word read, 10 word write, 11 auto-refresh.
  eng_addr  out  22  operation address.
  eng_len  out  8  burst length; 1 for word ops, 0 for refresh.
  eng_wdata  out  16  write data.
  eng_rdata  in  16  engine read data, valid with eng_done on word read.
  eng_done  in  1  one-cycle pulse; engine operation complete.
  lock  out  1  high while the SDRAM is unavailable to the CPU.

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT; IDLE->ISSUE on a grant, ISSUE->WAIT after exactly one cycle, WAIT->IDLE on the cycle eng_done is sampled high.
REQ-006 SHALL assert eng_start only in ISSUE, with eng_op/eng_addr/eng_len/eng_wdata registered at grant and held stable through WAIT.
REQ-007 SHALL not grant in IDLE while init_done=0.
REQ-008 SHALL grant in IDLE by priority: refresh if credits>=REFRESH_URGENT; else CPU if starve guard fires; else video; else CPU; else refresh if credits>0; else none.
REQ-009 SHALL pulse vid_ack or cpu_ack in the cycle after eng_done for the owning requester; no ack is issued for refresh.
REQ-010 SHALL capture eng_rdata into cpu_rdata on eng_done of a CPU read; cpu_rdata is otherwise held.
REQ-011 SHALL not regrant a requester in the cycle its ack is high; the earliest next grant is the cycle after the ack.
REQ-012 SHALL count refresh with a down-counter reloaded to REFRESH_INTERVAL-1; reaching 0 adds one credit, saturating at 7.
REQ-013 SHALL decrement credits on a refresh grant; a simultaneous increment and decrement leaves credits unchanged.
REQ-014 SHALL count consecutive video grants in a 2-bit starve counter while cpu_req=1, clear it on any CPU grant or while cpu_req=0, and fire the starve guard when the count equals STARVE_LIMIT.
REQ-015 SHALL drive lock=1 when init_done=0 or state!=IDLE, and lock=0 otherwise.
REQ-016 SHALL ignore eng_done while in IDLE or ISSUE.

Reset
REQ-017 SHALL, on reset_n=0 and asynchronously, enter IDLE and set eng_start=0, vid_ack=0, cpu_ack=0, lock=1, cpu_rdata=0, eng_op=0, eng_addr=0, eng_len=0, eng_wdata=0, credits=0, starve=0, and refresh counter=REFRESH_INTERVAL-1.
REQ-018 SHALL, when reset is asserted mid-operation, abandon the operation without issuing any ack.

Configuration
REQ-019 SHALL compile the starvation guard (REQ-014 and the starve term of REQ-008) only when SDRAM_ARB_STARVE_EN is defined; without the macro, arbitration is strict priority with video above CPU.

Structure
REQ-020 SHALL take the eng_op encodings and the state encoding from shared package sdram_pkg.
REQ-021 SHALL contain one sub-module, sdram_refresh_timer, which holds the counter and credits and has inputs for tick and decrement.

Verification
REQ-022 SHALL cover: init_done=0 with vid_req=1 for 100 cycles -> no eng_start, lock=1.
REQ-023 SHALL cover: CPU write of 0xBEEF to address 0x000123, with eng_done 5 cycles after eng_start -> eng_op=10, eng_wdata=0xBEEF, cpu_ack 1 cycle after eng_done.
REQ-024 SHALL cover: vid_req and cpu_req both held high, with SDRAM_ARB_STARVE_EN defined -> grant order V,V,V,C,V,V,V,C; without the macro -> V only.
REQ-025 SHALL cover: REFRESH_INTERVAL=16 with traffic that blocks refresh -> credits reach 4 and refresh is granted ahead of a pending vid_req.
REQ-026 SHALL cover: reset_n pulsed low during WAIT -> no ack, credits=0, lock=1 while init_done=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared types for the SDRAM front-end: arbiter state encoding, command-engine
// operation encoding, the internal grant selector and the burst-length helper.
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OP_BURST_RD = 2'b00,
    OP_WORD_RD  = 2'b01,
    OP_WORD_WR  = 2'b10,
    OP_REFRESH  = 2'b11
  } eng_op_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_REF  = 2'd3
  } grant_t;

  localparam logic [2:0] CREDIT_MAX = 3'd7;

  // A zero-length video burst is fetched as a single word.
  function automatic logic [7:0] burst_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// -----------------------------------------------------------------------------
// sdram_refresh_timer
// Free-running refresh interval counter plus a saturating pool of pending
// refresh credits.
//   clock, reset_n : clock and asynchronous active-low reset
//   tick           : count enable for the interval counter
//   dec            : consume one credit (a refresh has been granted)
//   credits        : pending refresh credits, 0..7
// -----------------------------------------------------------------------------
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       dec,
  output logic [2:0] credits
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] count;
  logic             inc;

  assign inc = tick && (count == '0);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= RELOAD;
    end else if (tick) begin
      count <= (count == '0) ? RELOAD : count - CNT_W'(1);
    end
  end

  // A credit earned in the same cycle one is consumed cancels out, which also
  // keeps a full pool at 7 instead of dropping to 6.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits <= '0;
    end else if (inc && !dec) begin
      if (credits != CREDIT_MAX) credits <= credits + 3'd1;
    end else if (dec && !inc) begin
      if (credits != '0) credits <= credits - 3'd1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Arbitrates a video line fetcher, a CPU word port and periodic auto-refresh
// onto a single SDRAM command engine. One operation is in flight at a time:
// IDLE (grant) -> ISSUE (eng_start pulse) -> WAIT (until eng_done).
//
// Ports
//   clock, reset_n           : clock, asynchronous active-low reset
//   init_done                : SDRAM initialised; no grants while low
//   vid_req/addr/len/ack     : video burst-read requester
//   cpu_req/we/addr/wdata    : CPU single-word requester
//   cpu_rdata/cpu_ack        : CPU read data (held) and completion pulse
//   eng_start/op/addr/len/wdata : command to the engine, stable through WAIT
//   eng_rdata/eng_done       : engine read data and completion pulse
//   lock                     : SDRAM unavailable to the CPU
//
// Build option
//   SDRAM_ARB_STARVE_EN : when defined, a CPU request that has watched
//   STARVE_LIMIT back-to-back video grants wins the next grant. Otherwise
//   priority is strictly refresh-urgent > video > CPU > refresh.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_URGENT   = 4,
  parameter int STARVE_LIMIT     = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        init_done,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  input  logic [7:0]  vid_len,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [21:0] eng_addr,
  output logic [7:0]  eng_len,
  output logic [15:0] eng_wdata,
  input  logic [15:0] eng_rdata,
  input  logic        eng_done,
  output logic        lock
);

  arb_state_t  state, state_nxt;
  grant_t      grant;
  eng_op_t     op_q;
  logic [2:0]  credits;
  logic        can_grant;
  logic        starve_fire;
  logic        done_now;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (1'b1),
    .dec     (grant == GNT_REF),
    .credits (credits)
  );

  // Nothing is granted in a cycle where an ack is out: the requester is still
  // holding req high for that one cycle and must not be served twice.
  assign can_grant = (state == IDLE) && init_done && !vid_ack && !cpu_ack;
  assign done_now  = (state == WAIT) && eng_done;

`ifdef SDRAM_ARB_STARVE_EN
  logic [1:0] starve;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (grant == GNT_CPU || !cpu_req) begin
      starve <= '0;
    end else if (grant == GNT_VID && starve != 2'd3) begin
      starve <= starve + 2'd1;
    end
  end

  assign starve_fire = (int'(starve) == STARVE_LIMIT);
`else
  // Guard compiled out; the constant-false term keeps the parameter referenced.
  assign starve_fire = (STARVE_LIMIT < 0);
`endif

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (can_grant) begin
      if (int'(credits) >= REFRESH_URGENT) grant = GNT_REF;
      else if (starve_fire && cpu_req)     grant = GNT_CPU;
      else if (vid_req)                    grant = GNT_VID;
      else if (cpu_req)                    grant = GNT_CPU;
      else if (credits != 3'd0)            grant = GNT_REF;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant != GNT_NONE) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command fields are captured at grant and left alone until the next grant,
  // so the engine sees them stable through ISSUE and WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= OP_BURST_RD;
      eng_addr  <= '0;
      eng_len   <= '0;
      eng_wdata <= '0;
    end else begin
      unique case (grant)
        GNT_VID: begin
          op_q      <= OP_BURST_RD;
          eng_addr  <= vid_addr;
          eng_len   <= burst_len(vid_len);
          eng_wdata <= '0;
        end
        GNT_CPU: begin
          op_q      <= cpu_we ? OP_WORD_WR : OP_WORD_RD;
          eng_addr  <= cpu_addr;
          eng_len   <= 8'd1;
          eng_wdata <= cpu_wdata;
        end
        GNT_REF: begin
          op_q      <= OP_REFRESH;
          eng_addr  <= '0;
          eng_len   <= 8'd0;
          eng_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // Owner of the finished operation is recovered from the latched opcode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      vid_ack <= done_now && (op_q == OP_BURST_RD);
      cpu_ack <= done_now && (op_q == OP_WORD_RD || op_q == OP_WORD_WR);
      if (done_now && op_q == OP_WORD_RD) cpu_rdata <= eng_rdata;
    end
  end

  assign eng_op    = op_q;
  assign eng_start = (state == ISSUE);
  assign lock      = !reset_n || !init_done || (state != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;

  typedef enum logic [1:0] {EV_START, EV_VACK, EV_CACK} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [1:0]  op;
    logic [21:0] addr;
    logic [7:0]  len;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // ---------------- main DUT (default refresh interval) ----------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b0, init_done = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, eng_done = 1'b0;
  logic [21:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0]  vid_len = '0;
  logic [15:0] cpu_wdata = '0, eng_rdata = '0;
  logic        vid_ack, cpu_ack, eng_start, lock;
  logic [15:0] cpu_rdata, eng_wdata;
  logic [1:0]  eng_op;
  logic [21:0] eng_addr;
  logic [7:0]  eng_len;

  sdram_arbiter dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .eng_start(eng_start), .eng_op(eng_op), .eng_addr(eng_addr), .eng_len(eng_len),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_done(eng_done), .lock(lock)
  );

  // ---------------- refresh DUT (short interval) ----------------
  logic        reset_r_n = 1'b0, init_done_r = 1'b0, vid_req_r = 1'b0, eng_done_r = 1'b0;
  logic [21:0] vid_addr_r = '0;
  logic [7:0]  vid_len_r = '0;
  logic        vid_ack_r, cpu_ack_r, eng_start_r, lock_r;
  logic [15:0] cpu_rdata_r, eng_wdata_r;
  logic [1:0]  eng_op_r;
  logic [21:0] eng_addr_r;
  logic [7:0]  eng_len_r;

  sdram_arbiter #(.REFRESH_INTERVAL(16), .REFRESH_URGENT(4), .STARVE_LIMIT(3)) dut_r (
    .clock(clock), .reset_n(reset_r_n), .init_done(init_done_r),
    .vid_req(vid_req_r), .vid_addr(vid_addr_r), .vid_len(vid_len_r), .vid_ack(vid_ack_r),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(22'h0), .cpu_wdata(16'h0),
    .cpu_rdata(cpu_rdata_r), .cpu_ack(cpu_ack_r),
    .eng_start(eng_start_r), .eng_op(eng_op_r), .eng_addr(eng_addr_r), .eng_len(eng_len_r),
    .eng_wdata(eng_wdata_r), .eng_rdata(16'h0), .eng_done(eng_done_r), .lock(lock_r)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(ev_kind_t k, logic [1:0] op, logic [21:0] a,
                             logic [7:0] l, logic [15:0] wd, logic [15:0] rd);
    ev_t e;
    e.kind = k; e.op = op; e.addr = a; e.len = l; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // ---------------- engine models ----------------
  int          eng_delay = 2;
  logic [15:0] eng_rdata_val = '0;
  int          done_cyc = -10;

  initial begin
    forever begin
      @(negedge clock);
      if (eng_start) begin
        repeat (eng_delay) @(negedge clock);
        eng_rdata = eng_rdata_val;
        eng_done  = 1'b1;
        done_cyc  = cyc;
        @(negedge clock);
        eng_done  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (eng_start_r) begin
        repeat (3) @(negedge clock);
        eng_done_r = 1'b1;
        @(negedge clock);
        eng_done_r = 1'b0;
      end
    end
  end

  // ---------------- main monitor / scoreboard ----------------
  int n_starts = 0;
  int n_acks = 0;

  task automatic take(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    case (k)
      EV_START: begin
        check("eng_op", eng_op, e.op);
        check("eng_addr", eng_addr, e.addr);
        check("eng_len", eng_len, e.len);
        check("eng_wdata", eng_wdata, e.wdata);
      end
      EV_CACK: begin
        check("cpu_rdata", cpu_rdata, e.rdata);
        check("cpu_ack_latency", cyc, done_cyc + 1);
      end
      EV_VACK: check("vid_ack_latency", cyc, done_cyc + 1);
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (eng_start) begin n_starts++; take(EV_START); end
      if (vid_ack)   begin n_acks++;   take(EV_VACK);  end
      if (cpu_ack)   begin n_acks++;   take(EV_CACK);  end
    end
  end

  // ---------------- refresh DUT monitor ----------------
  int   r_peak = 0;
  int   r_vid_starts = 0;
  logic r_ref_seen = 1'b0;
  logic r_done = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (!r_ref_seen && int'(dut_r.credits) > r_peak) r_peak = int'(dut_r.credits);
      if (eng_start_r && !r_ref_seen) begin
        if (eng_op_r == 2'b11) begin
          r_ref_seen = 1'b1;
          check("ref_peak_credits", r_peak, 4);
          check("ref_vid_pending", vid_req_r, 1'b1);
          check("ref_len", eng_len_r, 8'd0);
          check("ref_video_before", (r_vid_starts > 0), 1'b1);
        end else begin
          r_vid_starts++;
          check("r_vid_op", eng_op_r, 2'b00);
          check("r_vid_len", eng_len_r, 8'd16);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset_r_n = 1'b1; init_done_r = 1'b1;
    vid_addr_r = 22'h001000; vid_len_r = 8'd16; vid_req_r = 1'b1;
    for (int i = 0; i < 1000 && !r_ref_seen; i++) begin
      @(posedge clock);
      #1;
    end
    check("ref_granted", r_ref_seen, 1'b1);
    vid_req_r = 1'b0;
    r_done = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] last_rdata = '0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input logic init);
    reset_n = 1'b0; init_done = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    step(2);
    exp_q.delete();
    last_rdata = '0;
    reset_n = 1'b1;
    init_done = init;
    step(1);
  endtask

  task automatic cpu_op(input logic we, input logic [21:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int delay);
    int i;
    eng_delay = delay;
    eng_rdata_val = rd;
    if (!we) last_rdata = rd;
    exp_q.push_back(mk(EV_START, we ? 2'b10 : 2'b01, a, 8'd1, we ? wd : 16'h0, 16'h0));
    exp_q.push_back(mk(EV_CACK, 2'b00, 22'h0, 8'd0, 16'h0, last_rdata));
    cpu_we = we; cpu_addr = a; cpu_wdata = we ? wd : 16'h0; cpu_req = 1'b1;
    i = 0;
    while (!cpu_ack && i < 100) begin step(1); i++; end
    check("cpu_ack_seen", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    wait_drain("cpu_op", 10);
  endtask

  task automatic vid_op(input logic [21:0] a, input logic [7:0] l, input logic [7:0] exp_len,
                        input int delay);
    int i;
    eng_delay = delay;
    exp_q.push_back(mk(EV_START, 2'b00, a, exp_len, 16'h0, 16'h0));
    exp_q.push_back(mk(EV_VACK, 2'b00, 22'h0, 8'd0, 16'h0, 16'h0));
    vid_addr = a; vid_len = l; vid_req = 1'b1;
    i = 0;
    while (!vid_ack && i < 100) begin step(1); i++; end
    check("vid_ack_seen", vid_ack, 1'b1);
    vid_req = 1'b0;
    wait_drain("vid_op", 10);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_s, base_a, lock_bad;
    logic [7:0] cpu_slot;

    // Reset values
    step(1);
    check("rst_lock", lock, 1'b1);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_acks", {vid_ack, cpu_ack}, 2'b00);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    check("rst_eng_fields", {eng_op, eng_addr, eng_len}, 32'h0);
    check("rst_credits", dut.credits, 3'd0);

    // init_done low: video held for 100 cycles, nothing issued
    do_reset(1'b0);
    vid_addr = 22'h000200; vid_len = 8'd8; vid_req = 1'b1;
    base_s = n_starts;
    lock_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (lock !== 1'b1) lock_bad++;
    end
    check("init_no_start", n_starts - base_s, 0);
    check("init_lock_low_cycles", lock_bad, 0);
    vid_req = 1'b0;
    step(2);
    init_done = 1'b1;
    step(2);
    check("idle_lock", lock, 1'b0);

    // CPU write / read, video bursts incl. zero and max length
    cpu_op(1'b1, 22'h000123, 16'hBEEF, 16'h0, 5);
    cpu_op(1'b0, 22'h3FFFFF, 16'h0, 16'hA5C3, 1);
    vid_op(22'h2AAAAA, 8'd0, 8'd1, 2);
    vid_op(22'h000040, 8'd255, 8'd255, 4);
    check("cpu_rdata_held", cpu_rdata, 16'hA5C3);

    // Video and CPU held together
    do_reset(1'b1);
    vid_addr = 22'h000100; vid_len = 8'd4;
    cpu_we = 1'b0; cpu_addr = 22'h000055; cpu_wdata = 16'h0;
    eng_rdata_val = 16'h0C0C; eng_delay = 2;
`ifdef SDRAM_ARB_STARVE_EN
    cpu_slot = 8'b1000_1000;
`else
    cpu_slot = 8'b0000_0000;
`endif
    for (int i = 0; i < 8; i++) begin
      if (cpu_slot[i]) begin
        exp_q.push_back(mk(EV_START, 2'b01, 22'h000055, 8'd1, 16'h0, 16'h0));
        exp_q.push_back(mk(EV_CACK, 2'b00, 22'h0, 8'd0, 16'h0, 16'h0C0C));
      end else begin
        exp_q.push_back(mk(EV_START, 2'b00, 22'h000100, 8'd4, 16'h0, 16'h0));
        exp_q.push_back(mk(EV_VACK, 2'b00, 22'h0, 8'd0, 16'h0, 16'h0));
      end
    end
    base_s = n_starts;
    vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 400 && (n_starts - base_s) < 8; i++) step(1);
    vid_req = 1'b0; cpu_req = 1'b0;
    check("contend_grants", n_starts - base_s, 8);
    wait_drain("contend", 20);

    // Reset during WAIT abandons the operation
    do_reset(1'b1);
    eng_delay = 20;
    exp_q.push_back(mk(EV_START, 2'b10, 22'h000777, 8'd1, 16'h1111, 16'h0));
    cpu_we = 1'b1; cpu_addr = 22'h000777; cpu_wdata = 16'h1111;
    base_s = n_starts;
    base_a = n_acks;
    cpu_req = 1'b1;
    for (int i = 0; i < 50 && n_starts == base_s; i++) step(1);
    step(3);
    check("wait_lock", lock, 1'b1);
    reset_n = 1'b0; init_done = 1'b0; cpu_req = 1'b0;
    step(1);
    check("midrst_credits", dut.credits, 3'd0);
    check("midrst_lock", lock, 1'b1);
    check("midrst_eng_fields", {eng_op, eng_addr, eng_len}, 32'h0);
    check("midrst_eng_wdata", eng_wdata, 16'h0);
    reset_n = 1'b1;
    step(30);
    check("midrst_no_ack", n_acks - base_a, 0);
    check("midrst_starts", n_starts - base_s, 1);
    check("midrst_lock_after", lock, 1'b1);
    check("midrst_credits_after", dut.credits, 3'd0);
    check("midrst_queue", exp_q.size(), 0);

    for (int i = 0; i < 2000 && !r_done; i++) step(1);
    check("refresh_test_done", r_done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
